// File: rtl/tinyalu_master.sv
// Command/response front end that sequences one TinyALU operation at a time.
// Optional watchdog on the ALU handshake: define TINYALU_MASTER_TIMEOUT_EN.
module tinyalu_master #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [7:0]  cmd_a,
  input  logic [7:0]  cmd_b,
  output logic        start,
  output logic [2:0]  op,
  output logic [7:0]  A,
  output logic [7:0]  B,
  input  logic        done,
  input  logic [15:0] result,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_result,
  output logic        rsp_err
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_RESP} state_t;

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;

  if (TIMEOUT < 6 || TIMEOUT > 255) begin : g_bad_timeout
    $error("tinyalu_master: TIMEOUT must lie in 6..255");
  end

  state_t      r_state;
  logic        r_start;
  logic [2:0]  r_op;
  logic [7:0]  r_a;
  logic [7:0]  r_b;
  logic        r_rsp_valid;
  logic [15:0] r_rsp_result;
  logic        r_rsp_err;
`ifdef TINYALU_MASTER_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);
  logic [7:0]  r_cnt;
`endif

  // Gated by reset_n so the port reads 0 while reset is held.
  assign cmd_ready  = (r_state == S_IDLE) && reset_n;
  assign start      = r_start;
  assign op         = r_op;
  assign A          = r_a;
  assign B          = r_b;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_result = r_rsp_result;
  assign rsp_err    = r_rsp_err;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_start      <= 1'b0;
      r_op         <= 3'b000;
      r_a          <= 8'd0;
      r_b          <= 8'd0;
      r_rsp_valid  <= 1'b0;
      r_rsp_result <= 16'd0;
      r_rsp_err    <= 1'b0;
`ifdef TINYALU_MASTER_TIMEOUT_EN
      r_cnt        <= 8'd0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            case (cmd_op)
              OP_NOP: begin
                r_state      <= S_RESP;
                r_rsp_valid  <= 1'b1;
                r_rsp_result <= 16'd0;
                r_rsp_err    <= 1'b0;
              end
              OP_ADD, OP_AND, OP_XOR, OP_MUL: begin
                r_state <= S_RUN;
                r_start <= 1'b1;
                r_op    <= cmd_op;
                r_a     <= cmd_a;
                r_b     <= cmd_b;
`ifdef TINYALU_MASTER_TIMEOUT_EN
                r_cnt   <= 8'd0;
`endif
              end
              default: begin
                r_state      <= S_RESP;
                r_rsp_valid  <= 1'b1;
                r_rsp_result <= 16'd0;
                r_rsp_err    <= 1'b1;
              end
            endcase
          end
        end

        S_RUN: begin
`ifdef TINYALU_MASTER_TIMEOUT_EN
          r_cnt <= r_cnt + 8'd1;
`endif
          // done takes priority over an expiring watchdog in the same cycle.
          if (done) begin
            r_state      <= S_RESP;
            r_start      <= 1'b0;
            r_rsp_valid  <= 1'b1;
            r_rsp_result <= result;
            r_rsp_err    <= 1'b0;
          end
`ifdef TINYALU_MASTER_TIMEOUT_EN
          else if (r_cnt == TIMEOUT_LAST) begin
            r_state      <= S_RESP;
            r_start      <= 1'b0;
            r_rsp_valid  <= 1'b1;
            r_rsp_result <= 16'd0;
            r_rsp_err    <= 1'b1;
          end
`endif
        end

        S_RESP: begin
          if (rsp_ready) begin
            r_state     <= S_IDLE;
            r_rsp_valid <= 1'b0;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_start <= 1'b0;
        end
      endcase
    end
  end

endmodule
